// File: rtl/nabp_line_reader_pkg.sv
// Shared line-reader sizing defines plus FSM state and queue-depth constants.
// Optional reverse streaming is enabled by NABP_LINE_READER_REVERSE_EN.
`ifndef kFilteredDataLength
`define kFilteredDataLength 16
`endif
`ifndef kProjectionLineSize
`define kProjectionLineSize 16
`endif
`ifndef kSLength
`define kSLength 4
`endif

package nabp_line_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned QueueDepth = 2;
  localparam int unsigned QueueCntW  = $clog2(QueueDepth + 1);

endpackage

// File: rtl/nabp_projection_line_reader_if.sv
// Valid/ready sample stream leaving the projection line reader.
interface nabp_projection_line_reader_if #(
  parameter int unsigned pDataLength = `kFilteredDataLength
);
  logic [pDataLength-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/nabp_line_reader_fifo.sv
// Small output queue for the line reader; caller never pushes when full
// (unless popping) and never pops when empty.
module nabp_line_reader_fifo
  import nabp_line_reader_pkg::*;
#(
  parameter int unsigned pDataLength = `kFilteredDataLength
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [pDataLength-1:0] push_data,
  input  logic                   pop,
  output logic [pDataLength-1:0] head_data,
  output logic                   head_valid,
  output logic [QueueCntW-1:0]   count
);

  localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;

  logic [pDataLength-1:0] mem_q [QueueDepth];
  logic [pDataLength-1:0] mem_d [QueueDepth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [QueueCntW-1:0]   cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QueueDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + QueueCntW'(push) - QueueCntW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < QueueDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (cnt_q != '0);
  assign count      = cnt_q;

endmodule

// File: rtl/nabp_projection_line_reader.sv
// Streams a wrapped segment of a projection line out of a registered-read RAM.
// NABP_LINE_READER_REVERSE_EN adds the reverse input for decrementing addresses.
module nabp_projection_line_reader
  import nabp_line_reader_pkg::*;
#(
  parameter int unsigned pDataLength = `kFilteredDataLength,
  parameter int unsigned pRAMSize    = `kProjectionLineSize,
  parameter int unsigned pAddrLength = `kSLength
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [pAddrLength-1:0] start_addr,
  input  logic [pAddrLength:0]   length,
`ifdef NABP_LINE_READER_REVERSE_EN
  input  logic                   reverse,
`endif
  output logic [pAddrLength-1:0] ram_addr,
  input  logic [pDataLength-1:0] ram_data,
  nabp_projection_line_reader_if.master stream,
  output logic                   busy,
  output logic                   done
);

  localparam logic [pAddrLength-1:0] LastAddr = pAddrLength'(pRAMSize - 1);
  localparam logic [pAddrLength:0]   MaxLen   = (pAddrLength + 1)'(pRAMSize);
  localparam logic [pAddrLength:0]   OneLen   = (pAddrLength + 1)'(1);

  state_e                 state_q, state_d;
  logic [pAddrLength-1:0] addr_q, addr_d;
  logic [pAddrLength:0]   issue_left_q, issue_left_d;
  logic [pAddrLength:0]   beat_left_q, beat_left_d;
  logic                   bus_vld_q, bus_vld_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   zero_done_q, zero_done_d;
  logic                   rev_dir;
`ifdef NABP_LINE_READER_REVERSE_EN
  logic                   rev_q, rev_d;
  assign rev_dir = rev_q;
`else
  assign rev_dir = 1'b0;
`endif

  logic                   push, pop, blocked, issue_ok, final_beat;
  logic                   head_valid;
  logic [pDataLength-1:0] head_data;
  logic [QueueCntW-1:0]   count, occ_next;
  logic [pAddrLength:0]   len_sat;

  function automatic logic [pAddrLength-1:0] step(input logic [pAddrLength-1:0] a,
                                                  input logic rev);
    if (rev) return (a == '0) ? LastAddr : a - 1'b1;
    return (a == LastAddr) ? '0 : a + 1'b1;
  endfunction

  nabp_line_reader_fifo #(
    .pDataLength(pDataLength)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (ram_data),
    .pop       (pop),
    .head_data (head_data),
    .head_valid(head_valid),
    .count     (count)
  );

  // The RAM output register re-reads a held address, so a sample that finds the
  // queue full stays on ram_data until it fits; a new address is issued only
  // when the read already on the bus is certain to find a slot next cycle.
  assign pop        = head_valid & stream.out_ready;
  assign push       = rd_vld_q & ((count < QueueCntW'(QueueDepth)) | pop);
  assign occ_next   = count + QueueCntW'(push) - QueueCntW'(pop);
  assign blocked    = rd_vld_q & ~push;
  assign issue_ok   = ~blocked & (~bus_vld_q | (occ_next < QueueCntW'(QueueDepth)));
  assign final_beat = (beat_left_q == OneLen);
  assign len_sat    = (length > MaxLen) ? MaxLen : length;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    bus_vld_d    = 1'b0;
    rd_vld_d     = bus_vld_q | blocked;
    zero_done_d  = 1'b0;
`ifdef NABP_LINE_READER_REVERSE_EN
    rev_d        = rev_q;
`endif
    if (pop) begin
      beat_left_d = beat_left_q - 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_sat == '0) begin
            zero_done_d = 1'b1;
          end else begin
            addr_d       = start_addr;
            bus_vld_d    = 1'b1;
            issue_left_d = len_sat - 1'b1;
            beat_left_d  = len_sat;
            state_d      = (len_sat == OneLen) ? DRAIN : RUN;
`ifdef NABP_LINE_READER_REVERSE_EN
            rev_d        = reverse;
`endif
          end
        end
      end
      RUN: begin
        if (issue_ok) begin
          addr_d       = step(addr_q, rev_dir);
          bus_vld_d    = 1'b1;
          issue_left_d = issue_left_q - 1'b1;
          if (issue_left_q == OneLen) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && final_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      bus_vld_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      zero_done_q  <= 1'b0;
`ifdef NABP_LINE_READER_REVERSE_EN
      rev_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      bus_vld_q    <= bus_vld_d;
      rd_vld_q     <= rd_vld_d;
      zero_done_q  <= zero_done_d;
`ifdef NABP_LINE_READER_REVERSE_EN
      rev_q        <= rev_d;
`endif
    end
  end

  assign ram_addr         = addr_q;
  assign busy             = (state_q != IDLE);
  assign done             = zero_done_q | (pop & final_beat & (state_q == DRAIN));
  assign stream.out_data  = head_data;
  assign stream.out_valid = head_valid;
  assign stream.out_last  = head_valid & final_beat;

endmodule

// File: doc/nabp_projection_line_reader.md
NABP_PROJECTION_LINE_READER -- requirements
Module: nabp_projection_line_reader

Interface
REQ-001 SHALL take parameter pDataLength, default `kFilteredDataLength, sample width.
REQ-002 SHALL take parameter pRAMSize, default `kProjectionLineSize, RAM depth in samples.
REQ-003 SHALL take parameter pAddrLength, default `kSLength, log2(pRAMSize).
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request to stream one line segment.
REQ-007 SHALL have port start_addr, input, pAddrLength, first RAM address.
REQ-008 SHALL have port length, input, pAddrLength+1, sample count, 0..pRAMSize.
REQ-009 SHALL have port ram_addr, output, pAddrLength, read address to a dual-port RAM port with write enable held low.
REQ-010 SHALL have port ram_data, input, pDataLength, RAM registered read data, valid one cycle after ram_addr.
REQ-011 SHALL have ports out_data (output, pDataLength), out_valid (output, 1), out_ready (input, 1), out_last (output, 1), forming a valid/ready stream.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-014 IDLE->RUN when start is high in IDLE; start_addr and length are captured that cycle; start is ignored outside IDLE.
REQ-015 length 0 SHALL pulse done the cycle after start, with no output beats and no return to RUN.
REQ-016 length greater than pRAMSize SHALL saturate to pRAMSize.
REQ-017 In RUN, issue one address per cycle; address increments modulo pRAMSize, wrapping from pRAMSize-1 to 0.
REQ-018 Issue only while (queue occupancy + reads in flight) < 2; ram_addr holds its value when not issuing.
REQ-019 Returned data SHALL enter a 2-entry queue; out_data and out_valid come from the queue head.
REQ-020 A beat transfers when out_valid and out_ready are both high; out_valid SHALL NOT drop until the beat transfers.
REQ-021 out_last SHALL be high only on the final beat of the segment.
REQ-022 RUN->DRAIN after the final address issues; DRAIN->IDLE when the final beat transfers; done pulses that same cycle.
REQ-023 Latency: start high at cycle T -> ram_addr=start_addr in T+1 -> earliest out_valid in T+3.
REQ-024 With out_ready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-025 busy SHALL be high in RUN and DRAIN, low in IDLE.

Reset
REQ-026 reset asserted at any time, including mid-segment, SHALL force IDLE and flush the queue and in-flight tracking.
REQ-027 Reset values SHALL be: ram_addr 0, out_data 0, out_valid 0, out_last 0, busy 0, done 0.
REQ-028 The first start after reset deasserts SHALL be honoured on the first rising edge.

Configuration
REQ-029 Macro NABP_LINE_READER_REVERSE_EN SHALL control reverse streaming.
REQ-030 With NABP_LINE_READER_REVERSE_EN defined, the block SHALL add input reverse (1 bit), captured at start; when reverse is high, addresses decrement modulo pRAMSize, wrapping from 0 to pRAMSize-1.
REQ-031 Without NABP_LINE_READER_REVERSE_EN, the reverse port SHALL NOT exist and addressing is increment-only.

Structure
REQ-032 FSM state encodings and the queue depth constant (2) SHALL live in shared package nabp_line_reader_pkg.
REQ-033 The length and address constants SHALL stay in the existing shared defines.
REQ-034 The 2-entry queue SHALL be sub-module nabp_line_reader_fifo.

Verification
REQ-035 Scenario: start_addr=0, length=8, out_ready=1, RAM[i]=i -> beats 0..7 on consecutive cycles; out_last on 7; done on the same cycle as that beat.
REQ-036 Scenario: pRAMSize=16, start_addr=14, length=4 -> beats RAM[14], RAM[15], RAM[0], RAM[1].
REQ-037 Scenario: length=8 with out_ready toggling 1,0,0,1 -> all 8 beats in order, none dropped or duplicated, out_valid stable while stalled.
REQ-038 Scenario: length=0 -> done pulses at T+1, out_valid never asserts, busy stays low.
REQ-039 Scenario: reset asserted after 3 of 8 beats -> all outputs 0 asynchronously; a new start with start_addr=5, length=2 streams RAM[5], RAM[6].
REQ-040 Scenario (macro defined): reverse=1, start_addr=1, length=3, pRAMSize=16 -> beats RAM[1], RAM[0], RAM[15].
